// File: rtl/mac_pkg.sv
// mac_pkg: shared operand/accumulator widths, FSM encoding and default vector length
package mac_pkg;
   localparam int OP_W = 8;
   localparam int ACC_W = 16;
   localparam int MAX_LEN_DEF = 64;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mac_unit.sv
// mac_unit: combinational multiply-add, mac_out = a*b + acc modulo 2^16
module mac_unit
   import mac_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [ACC_W-1:0] acc,
   output logic [ACC_W-1:0] mac_out
);
   assign mac_out = ACC_W'(a) * ACC_W'(b) + acc;
endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: streaming dot-product controller around mac_unit; MAC_DOT_SAT_EN enables accumulator saturation
module mac_dot_seq
   import mac_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             overflow
);
   state_t state, state_n;
   logic [ACC_W-1:0] acc, acc_n, acc_in, acc_wr, mac_out, prod;
   logic [CNT_W-1:0] count, count_n, count_inc;
   logic ovf, ovf_n, carry, accept, beat_last;

   mac_unit u_mac (.a(in_a), .b(in_b), .acc(acc_in), .mac_out(mac_out));

   assign in_ready = state != DONE;
   assign out_valid = state == DONE;
   assign out_sum = acc;
   assign out_count = count;
   assign overflow = ovf;
   assign accept = in_valid && in_ready;
   assign acc_in = state == ACCUM ? acc : '0;
   assign prod = ACC_W'(in_a) * ACC_W'(in_b);
   assign carry = |(({1'b0, prod} + {1'b0, acc_in}) >> ACC_W);
   assign count_inc = (state == ACCUM ? count : CNT_W'(0)) + CNT_W'(1);
   assign beat_last = in_last || count_inc == CNT_W'(MAX_LEN);
`ifdef MAC_DOT_SAT_EN
   assign acc_wr = carry ? '1 : mac_out;
`else
   assign acc_wr = mac_out;
`endif

   // next-state: accumulate on accepted beats, clear on result handshake
   always_comb begin
      state_n = state;
      acc_n = acc;
      count_n = count;
      ovf_n = ovf;
      if (accept) begin
         acc_n = acc_wr;
         count_n = count_inc;
         ovf_n = (state == ACCUM && ovf) || carry;
         state_n = beat_last ? DONE : ACCUM;
      end else if (state == DONE && out_ready) begin
         state_n = IDLE;
         acc_n = '0;
         count_n = '0;
         ovf_n = 1'b0;
      end
   end

   // state register; reset discards any partial vector
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc <= '0;
         count <= '0;
         ovf <= 1'b0;
      end else begin
         state <= state_n;
         acc <= acc_n;
         count <= count_n;
         ovf <= ovf_n;
      end
   end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: table-driven and scoreboarded checks of mac_dot_seq with MAX_LEN=4
module tb_mac_dot_seq;
   localparam int ML = 4;

   typedef struct packed {
      logic [2:0]      n;
      logic [3:0][7:0] a;
      logic [3:0][7:0] b;
      logic [15:0]     sum;
      logic [2:0]      cnt;
      logic            ovf;
   } vec_t;

   typedef struct packed {
      logic [15:0] sum;
      logic [2:0]  cnt;
      logic        ovf;
   } exp_t;

   logic clk = 0, rst = 1, in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 0, overflow;
   logic [7:0] in_a = 0, in_b = 0;
   logic [15:0] out_sum;
   logic [2:0] out_count;
   int tests = 0, fails = 0;
   exp_t q[$];
   vec_t tbl[4];
   logic [15:0] m_acc = 0;
   int m_cnt = 0;
   logic m_ovf = 0;

   mac_dot_seq #(.MAX_LEN(ML), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
      int g = 0;
      in_valid = 1; in_a = a; in_b = b; in_last = l;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) check("accept_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input logic l);
      int s;
      s = int'(m_acc) + int'(a) * int'(b);
      m_ovf = m_ovf | (s > 65535);
`ifdef MAC_DOT_SAT_EN
      m_acc = s > 65535 ? 16'hFFFF : 16'(s);
`else
      m_acc = 16'(s);
`endif
      m_cnt++;
      if (l || m_cnt == ML) begin
         q.push_back('{m_acc, 3'(m_cnt), m_ovf});
         m_acc = 0; m_cnt = 0; m_ovf = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) check("unexpected_result", out_count, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("sb_sum", out_sum, e.sum);
            check("sb_count", out_count, e.cnt);
            check("sb_overflow", overflow, e.ovf);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0].n = 1; tbl[0].a = {8'd0, 8'd0, 8'd0, 8'd3}; tbl[0].b = {8'd0, 8'd0, 8'd0, 8'd4};
      tbl[0].sum = 16'd12; tbl[0].cnt = 1; tbl[0].ovf = 0;
      tbl[1].n = 3; tbl[1].a = {8'd0, 8'd5, 8'd3, 8'd1}; tbl[1].b = {8'd0, 8'd6, 8'd4, 8'd2};
      tbl[1].sum = 16'd44; tbl[1].cnt = 3; tbl[1].ovf = 0;
      tbl[2].n = 2; tbl[2].a = {8'd0, 8'd0, 8'd255, 8'd255}; tbl[2].b = {8'd0, 8'd0, 8'd255, 8'd255};
`ifdef MAC_DOT_SAT_EN
      tbl[2].sum = 16'hFFFF;
`else
      tbl[2].sum = 16'hFC02;
`endif
      tbl[2].cnt = 2; tbl[2].ovf = 1;
      tbl[3].n = 3; tbl[3].a = {8'd0, 8'd7, 8'd0, 8'd10}; tbl[3].b = {8'd0, 8'd9, 8'd0, 8'd20};
      tbl[3].sum = 16'd263; tbl[3].cnt = 3; tbl[3].ovf = 0;

      repeat (3) @(posedge clk);
      #1 rst = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_count", out_count, 0);
      check("rst_overflow", overflow, 0);

      for (int r = 0; r < 4; r++) begin
         out_ready = 0;
         q.push_back('{tbl[r].sum, tbl[r].cnt, tbl[r].ovf});
         for (int k = 0; k < int'(tbl[r].n); k++) send(tbl[r].a[k], tbl[r].b[k], k == int'(tbl[r].n) - 1);
         check("row_out_valid", out_valid, 1);
         check("row_in_ready_done", in_ready, 0);
         @(posedge clk); #1;
         check("row_held_sum", out_sum, tbl[r].sum);
         check("row_held_count", out_count, tbl[r].cnt);
         out_ready = 1;
         @(posedge clk); #1;
         out_ready = 0;
         check("row_in_ready_after", in_ready, 1);
         check("row_out_valid_after", out_valid, 0);
         check("row_cleared_sum", out_sum, 0);
      end

      q.push_back('{16'd6, 3'd1, 1'b0});
      send(8'd2, 8'd3, 1'b1);
      in_valid = 1; in_a = 9; in_b = 9; in_last = 1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("bp_sum", out_sum, 6);
         check("bp_count", out_count, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      q.push_back('{16'd81, 3'd1, 1'b0});
      out_ready = 1;
      send(8'd9, 8'd9, 1'b1);
      repeat (2) @(posedge clk); #1;

      q.push_back('{16'd4, 3'd4, 1'b0});
      q.push_back('{16'd3, 3'd3, 1'b0});
      for (int i = 0; i < 7; i++) begin
         send(8'd1, 8'd1, i == 6);
         if (i == 3) begin
            check("maxlen_out_valid", out_valid, 1);
            check("maxlen_count", out_count, 4);
         end
      end
      repeat (2) @(posedge clk); #1;

      send(8'd2, 8'd2, 1'b0);
      send(8'd2, 8'd2, 1'b0);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_sum", out_sum, 0);
      check("midrst_count", out_count, 0);
      rst = 1; in_valid = 1; in_a = 2; in_b = 2; in_last = 1;
      @(posedge clk); #1;
      rst = 0; in_valid = 0;
      check("rstwin_out_valid", out_valid, 0);
      check("rstwin_count", out_count, 0);
      q.push_back('{16'd1, 3'd1, 1'b0});
      send(8'd1, 8'd1, 1'b1);
      repeat (2) @(posedge clk); #1;

      for (int v = 0; v < 20; v++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            logic [7:0] a, b;
            logic l;
            repeat ($urandom_range(0, 2)) begin
               in_valid = 0; in_last = 1'($urandom);
               @(posedge clk); #1;
            end
            a = $urandom_range(0, 1) ? 8'($urandom_range(200, 255)) : 8'($urandom);
            b = $urandom_range(0, 1) ? 8'($urandom_range(200, 255)) : 8'($urandom);
            l = i == len - 1;
            model_beat(a, b, l);
            send(a, b, l);
         end
      end
      in_last = 0;
      repeat (5) @(posedge clk); #1;
      check("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
